// File: rtl/dm_handshake_mem.sv
// -----------------------------------------------------------------------------
// dm_handshake_mem
//   Multi-cycle data memory for the MEM stage. Byte/half/word loads and stores
//   are taken through a valid/ready request channel and answered with a
//   one-cycle response pulse after a programmable latency. Each access is
//   checked for misalignment, for falling outside the address window, and for
//   the reserved size code. Committed stores are reported on a trace port.
//
//   Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both 1. All req_* fields are captured on that edge. The
//   requester must hold them stable until then. req_ready is 1 in IDLE and RESP
//   and 0 in WAIT. Every accepted request produces exactly one rsp_valid pulse
//   (unless reset intervenes), LAT cycles after the cycle in which it was
//   accepted. A request presented in the RESP cycle is accepted back-to-back.
//
// Parameters
//   DEPTH_W    number of 32-bit words (power of two, >= 2)
//   LAT        cycles from accept to response, >= 1
//   BASE_ADDR  byte address of word 0
//
// Ports
//   clk, reset     clock (rising edge), synchronous active-high reset
//   req_*          request channel (valid/ready, we, size, unsigned, addr,
//                  wdata, pc)
//   rsp_valid      one-cycle response pulse
//   rsp_rdata      extended load data (0 for stores and errors)
//   rsp_err        access error, qualified by rsp_valid
//   trace_*        committed-store report, pulses with rsp_valid
//   fsm_state      current FSM state (0=IDLE, 1=WAIT, 2=RESP), for debug
// -----------------------------------------------------------------------------
module dm_handshake_mem #(
   parameter int          DEPTH_W   = 4096,
   parameter int          LAT       = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        trace_valid,
   output logic [31:0] trace_pc,
   output logic [31:0] trace_addr,
   output logic [31:0] trace_data,
   output logic [1:0]  fsm_state
);

   localparam int          IDX_W     = $clog2(DEPTH_W);
   localparam int          CNT_W     = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [32:0] WIN_BYTES = 33'(DEPTH_W) * 33'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [31:0]        mem [DEPTH_W];

   // Latched request
   logic               l_we;
   logic [1:0]         l_size;
   logic               l_uns;
   logic [31:0]        l_addr;
   logic [31:0]        l_wdata;
   logic [31:0]        l_pc;

   logic               accept;
   logic [32:0]        off;
   logic               in_window;
   logic               misaligned;
   logic               err;
   logic [IDX_W-1:0]   idx;
   logic [31:0]        old_word;
   logic [7:0]         ld_byte;
   logic [15:0]        ld_half;
   logic [31:0]        ld_data;
   logic [31:0]        merged;
   logic               store_ok;

   assign accept    = req_valid && req_ready;
   assign fsm_state = state;

   // ---------------------------------------------------------------------------
   // Address decode and error check on the latched request. The subtraction is
   // done in 33 bits so an address below BASE_ADDR shows up as a borrow rather
   // than wrapping into the window.
   // ---------------------------------------------------------------------------
   assign off        = {1'b0, l_addr} - {1'b0, BASE_ADDR};
   assign in_window  = !off[32] && (off < WIN_BYTES);
   assign misaligned = ((l_size == 2'd1) && l_addr[0]) ||
                       ((l_size == 2'd2) && (l_addr[1:0] != 2'b00));
   assign err        = !in_window || misaligned || (l_size == 2'd3);
   assign idx        = off[IDX_W+1:2];
   assign old_word   = mem[idx];
   assign store_ok   = l_we && !err;

   // Load lane extraction and extension
   always_comb begin
      ld_byte = old_word[7:0];
      ld_half = l_addr[1] ? old_word[31:16] : old_word[15:0];
      ld_data = '0;
      case (l_addr[1:0])
         2'd0:    ld_byte = old_word[7:0];
         2'd1:    ld_byte = old_word[15:8];
         2'd2:    ld_byte = old_word[23:16];
         default: ld_byte = old_word[31:24];
      endcase
      case (l_size)
         2'd0:    ld_data = {{24{~l_uns & ld_byte[7]}}, ld_byte};
         2'd1:    ld_data = {{16{~l_uns & ld_half[15]}}, ld_half};
         2'd2:    ld_data = old_word;
         default: ld_data = '0;
      endcase
   end

   // Store merge: replace only the addressed lane of the current word
   always_comb begin
      merged = old_word;
      case (l_size)
         2'd0: begin
            case (l_addr[1:0])
               2'd0:    merged[7:0]   = l_wdata[7:0];
               2'd1:    merged[15:8]  = l_wdata[7:0];
               2'd2:    merged[23:16] = l_wdata[7:0];
               default: merged[31:24] = l_wdata[7:0];
            endcase
         end
         2'd1: begin
            if (l_addr[1]) merged[31:16] = l_wdata[15:0];
            else           merged[15:0]  = l_wdata[15:0];
         end
         2'd2:    merged = l_wdata;
         default: merged = old_word;
      endcase
   end

   // Response and trace outputs are qualified by the registered rsp_valid, so
   // they read as 0 outside the RESP cycle.
   assign rsp_err     = rsp_valid && err;
   assign rsp_rdata   = (rsp_valid && !l_we && !err) ? ld_data : 32'h0;
   assign trace_valid = rsp_valid && store_ok;
   assign trace_pc    = trace_valid ? l_pc : 32'h0;
   assign trace_addr  = trace_valid ? {l_addr[31:2], 2'b00} : 32'h0;
   assign trace_data  = trace_valid ? merged : 32'h0;

   // ---------------------------------------------------------------------------
   // FSM, request latch and memory write. Reset wins over everything, so a
   // reset during WAIT or RESP drops the access without writing.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         l_we      <= 1'b0;
         l_size    <= 2'd0;
         l_uns     <= 1'b0;
         l_addr    <= 32'h0;
         l_wdata   <= 32'h0;
         l_pc      <= 32'h0;
         for (int i = 0; i < DEPTH_W; i++) begin
            mem[i] <= 32'h0;
         end
      end else begin
         if (accept) begin
            l_we    <= req_we;
            l_size  <= req_size;
            l_uns   <= req_unsigned;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
            l_pc    <= req_pc;
         end

         // The store commits on the edge that ends RESP, after which a
         // following load reads the updated word in its own RESP cycle.
         if ((state == RESP) && store_ok) begin
            mem[idx] <= merged;
         end

         case (state)
            IDLE, RESP: begin
               if (accept) begin
                  if (LAT > 1) begin
                     state     <= WAIT;
                     cnt       <= CNT_W'(LAT - 1);
                     req_ready <= 1'b0;
                     rsp_valid <= 1'b0;
                  end else begin
                     state     <= RESP;
                     req_ready <= 1'b1;
                     rsp_valid <= 1'b1;
                  end
               end else begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
               end
            end
            WAIT: begin
               if (cnt == CNT_W'(1)) begin
                  state     <= RESP;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_handshake_mem.sv
module tb_dm_handshake_mem;

   localparam int          DEPTH_W   = 4096;
   localparam int          LAT       = 2;
   localparam logic [31:0] BASE_ADDR = 32'h0;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        trace_valid;
   logic [31:0] trace_pc;
   logic [31:0] trace_addr;
   logic [31:0] trace_data;
   logic [1:0]  fsm_state;

   int checks = 0;
   int errors = 0;

   dm_handshake_mem #(
      .DEPTH_W   (DEPTH_W),
      .LAT       (LAT),
      .BASE_ADDR (BASE_ADDR)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_pc       (req_pc),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .trace_valid  (trace_valid),
      .trace_pc     (trace_pc),
      .trace_addr   (trace_addr),
      .trace_data   (trace_data),
      .fsm_state    (fsm_state)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] pc);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_pc       = pc;
   endtask

   task automatic idle_inputs();
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      req_pc       = 32'h0;
   endtask

   // One isolated request: wait for ready, transfer, find the response pulse,
   // check its latency and contents, then check that it lasts one cycle.
   task automatic issue(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic exp_trace, input logic [31:0] exp_tdata);
      int n;
      int lat;
      logic [31:0] exp_taddr;
      exp_taddr = {addr[31:2], 2'b00};
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
      drive(we, size, uns, addr, wdata, pc);
      @(posedge clk);
      #1 idle_inputs();
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < LAT + 4);
      chk({tag, ".latency"}, lat, LAT);
      chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
      chk({tag, ".err"}, {31'b0, rsp_err}, {31'b0, exp_err});
      chk({tag, ".trace_valid"}, {31'b0, trace_valid}, {31'b0, exp_trace});
      if (exp_trace) begin
         chk({tag, ".trace_addr"}, trace_addr, exp_taddr);
         chk({tag, ".trace_data"}, trace_data, exp_tdata);
         chk({tag, ".trace_pc"}, trace_pc, pc);
      end
      @(negedge clk);
      chk({tag, ".pulse_end"}, {31'b0, rsp_valid}, 32'd0);
   endtask

   initial begin
      int cyc;
      int n_acc;
      int n_rsp;
      int last_rsp;
      logic        accepting;
      logic [31:0] b2b_addr [3];
      logic [31:0] b2b_exp  [3];

      // reset
      reset = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst.req_ready",   {31'b0, req_ready},   32'd1);
      chk("rst.rsp_valid",   {31'b0, rsp_valid},   32'd0);
      chk("rst.rsp_err",     {31'b0, rsp_err},     32'd0);
      chk("rst.rsp_rdata",   rsp_rdata,            32'h0);
      chk("rst.trace_valid", {31'b0, trace_valid}, 32'd0);
      chk("rst.trace_pc",    trace_pc,             32'h0);
      chk("rst.trace_addr",  trace_addr,           32'h0);
      chk("rst.trace_data",  trace_data,           32'h0);
      chk("rst.state",       {30'b0, fsm_state},   32'd0);

      // word store then load
      issue("sw10",  1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 32'h100,
            32'h0, 1'b0, 1'b1, 32'h12345678);
      issue("lw10",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h104,
            32'h12345678, 1'b0, 1'b0, 32'h0);

      // byte store into the middle of the word, signed/unsigned byte loads
      issue("sb11",  1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFFAB, 32'h108,
            32'h0, 1'b0, 1'b1, 32'h1234AB78);
      issue("lb11",  1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'h10C,
            32'hFFFFFFAB, 1'b0, 1'b0, 32'h0);
      issue("lbu11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'h110,
            32'h000000AB, 1'b0, 1'b0, 32'h0);
      issue("lb13",  1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h114,
            32'h00000012, 1'b0, 1'b0, 32'h0);

      // half store to the upper lane, signed/unsigned half loads
      issue("sh22",  1'b1, 2'd1, 1'b0, 32'h22, 32'h5A5A8001, 32'h118,
            32'h0, 1'b0, 1'b1, 32'h80010000);
      issue("lh22",  1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'h11C,
            32'hFFFF8001, 1'b0, 1'b0, 32'h0);
      issue("lhu22", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h120,
            32'h00008001, 1'b0, 1'b0, 32'h0);
      issue("lw20",  1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h124,
            32'h80010000, 1'b0, 1'b0, 32'h0);

      // errors: misaligned word, misaligned half, out of window, reserved size
      issue("err_lw13", 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'h128,
            32'h0, 1'b1, 1'b0, 32'h0);
      issue("err_sh21", 1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFFFFFF, 32'h12C,
            32'h0, 1'b1, 1'b0, 32'h0);
      issue("err_swwin", 1'b1, 2'd2, 1'b0, BASE_ADDR + 32'h4000, 32'hCAFEF00D, 32'h130,
            32'h0, 1'b1, 1'b0, 32'h0);
      issue("err_sz3", 1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h134,
            32'h0, 1'b1, 1'b0, 32'h0);
      issue("post_err_lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h138,
            32'h1234AB78, 1'b0, 1'b0, 32'h0);
      issue("post_err_lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h13C,
            32'h80010000, 1'b0, 1'b0, 32'h0);
      issue("post_err_lw0",  1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h140,
            32'h0, 1'b0, 1'b0, 32'h0);

      // back-to-back: three loads with req_valid held high
      b2b_addr[0] = 32'h10; b2b_exp[0] = 32'h1234AB78;
      b2b_addr[1] = 32'h20; b2b_exp[1] = 32'h80010000;
      b2b_addr[2] = 32'h14; b2b_exp[2] = 32'h00000000;
      @(negedge clk);
      drive(1'b0, 2'd2, 1'b0, b2b_addr[0], 32'h0, 32'h200);
      cyc = 0; n_acc = 0; n_rsp = 0; last_rsp = 0;
      while (n_rsp < 3 && cyc < 40) begin
         accepting = req_valid && req_ready;
         @(posedge clk);
         #1;
         if (accepting) begin
            n_acc++;
            if (n_acc < 3) drive(1'b0, 2'd2, 1'b0, b2b_addr[n_acc], 32'h0, 32'h200 + 32'(4 * n_acc));
            else           idle_inputs();
         end
         @(negedge clk);
         cyc++;
         if (rsp_valid) begin
            chk($sformatf("b2b.rdata%0d", n_rsp), rsp_rdata, b2b_exp[n_rsp]);
            if (n_rsp > 0) chk($sformatf("b2b.spacing%0d", n_rsp), cyc - last_rsp, LAT);
            else           chk("b2b.first_latency", cyc, LAT);
            last_rsp = cyc;
            n_rsp++;
         end
      end
      chk("b2b.responses", n_rsp, 3);
      chk("b2b.accepts", n_acc, 3);
      idle_inputs();
      @(negedge clk);
      chk("b2b.idle_after", {30'b0, fsm_state}, 32'd0);

      // reset during WAIT after a store accept
      @(negedge clk);
      drive(1'b1, 2'd2, 1'b0, 32'h30, 32'hDEADBEEF, 32'h300);
      @(posedge clk);
      #1 idle_inputs();
      chk("rstwait.state_wait", {30'b0, fsm_state}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rstwait.req_ready", {31'b0, req_ready}, 32'd1);
      chk("rstwait.rsp_valid", {31'b0, rsp_valid}, 32'd0);
      n_rsp = 0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid) n_rsp++;
      end
      chk("rstwait.no_response", n_rsp, 0);
      issue("rstwait.lw30", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h304,
            32'h0, 1'b0, 1'b0, 32'h0);
      issue("rstwait.lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h308,
            32'h0, 1'b0, 1'b0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
